// File: rtl/AESDefinitions.sv
// Shared AES-128 types and constants: key/word types, round constants and the
// encrypt-path S-box used by both forward and inverse key expansion.
package AESDefinitions;

  typedef logic [127:0] roundKey_t;
  typedef logic [31:0]  keyWord_t;

  // Rcon[r] for r = 1..10 in the top byte; unused indices read as zero.
  localparam keyWord_t RCON [0:15] = '{
    32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
    32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
    32'h80000000, 32'h1b000000, 32'h36000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Byte b lives at bit offset (255 - b) * 8, i.e. {~b, 3'b000}.
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit key word.
module sub_word
  import AESDefinitions::*;
(
  input  keyWord_t word_i,
  output keyWord_t word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      word_o[i*8 +: 8] = sbox(word_i[i*8 +: 8]);
    end
  end

endmodule

// File: rtl/inverse_key_schedule.sv
// AES-128 reverse key schedule: emits round keys 10 down to 0 from the
// round-10 key, one per accepted handshake, derived combinationally.
module inverse_key_schedule
  import AESDefinitions::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  roundKey_t  lastKey,
  input  logic       keyReady,
  output roundKey_t  roundKey,
  output logic [3:0] roundNum,
  output logic       keyValid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EMIT = 2'b01
  } state_e;

  state_e     state_q, state_d;
  roundKey_t  key_q, key_d;
  logic [3:0] round_q, round_d;
  logic       done_q, done_d;

  keyWord_t  k0, k1, k2, k3;
  keyWord_t  p0, p1, p2, p3;
  keyWord_t  rot_w, sub_w;
  roundKey_t prev_key;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  assign p3    = k3 ^ k2;
  assign p2    = k2 ^ k1;
  assign p1    = k1 ^ k0;
  assign rot_w = {p3[23:0], p3[31:24]};

  sub_word u_sub_word (
    .word_i (rot_w),
    .word_o (sub_w)
  );

  assign p0       = k0 ^ sub_w ^ RCON[round_q];
  assign prev_key = {p0, p1, p2, p3};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      EMIT: begin
        if (keyReady) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: begin
        // Illegal encodings fall here and recover to IDLE; a start coinciding
        // with the done pulse is ignored so each run needs a fresh request.
        state_d = IDLE;
        if (start && !done_q) begin
          state_d = EMIT;
          key_d   = lastKey;
          round_d = 4'd10;
        end
      end
    endcase
  end

  always_comb begin
    keyValid = (state_q == EMIT);
    busy     = (state_q == EMIT);
    roundKey = key_q;
    roundNum = round_q;
    done     = done_q;
  end

endmodule

// File: tb/tb_inverse_key_schedule.sv
// Scoreboard bench for inverse_key_schedule with an independent AES key model.
module tb_inverse_key_schedule;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         keyReady = 1'b1;
  logic [127:0] lastKey = '0;
  logic [127:0] roundKey;
  logic [3:0]   roundNum;
  logic         keyValid, busy, done;

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clock = ~clock;

  inverse_key_schedule dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .lastKey  (lastKey),
    .keyReady (keyReady),
    .roundKey (roundKey),
    .roundNum (roundNum),
    .keyValid (keyValid),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [3:0]   rn;
    logic [127:0] key;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           accepts = 0;
  int           dones = 0;
  logic [7:0]   sbox_m [256];
  bit           rand_ready = 1'b0;
  bit           stray_en = 1'b0;
  logic [127:0] stray_key = '0;
  logic         hold_v = 1'b0;
  logic [127:0] held_key = '0;
  logic [3:0]   held_rn = '0;
  logic [127:0] last_r0 = '0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] a);
    return {a[6:0], a[7]};
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [31:0] m_rcon(input int r);
    logic [7:0] rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    return {rc, 24'h000000};
  endfunction

  function automatic logic [127:0] m_inv(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ m_sub({w3[23:0], w3[31:24]}) ^ m_rcon(r);
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] m_fwd(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ m_sub({k[23:0], k[31:24]}) ^ m_rcon(r);
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic push_run(input logic [127:0] key, input bit fips);
    logic [127:0] k = key;
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rn  = 4'(r);
      e.key = k;
      if (fips && r == 9) e.key = K9;
      if (fips && r == 0) e.key = K0;
      sb_q.push_back(e);
      if (r > 0) k = m_inv(k, r);
    end
  endtask

  // Monitor: sampled on the falling edge, an accept happens at the next rise.
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) dones++;
    if (keyValid === 1'b1) begin
      if (hold_v) begin
        check_eq("hold_key", roundKey, held_key);
        check_eq("hold_rn", 128'(roundNum), 128'(held_rn));
      end
      if (keyReady) begin
        check_eq("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("sb_rn", 128'(roundNum), 128'(e.rn));
          check_eq("sb_key", roundKey, e.key);
        end
        accepts++;
        if (roundNum == 4'd0) last_r0 = roundKey;
      end
    end
    hold_v   = (keyValid === 1'b1) && !keyReady;
    held_key = roundKey;
    held_rn  = roundNum;
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      keyReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulse_start(input logic [127:0] key);
    @(posedge clock);
    #1;
    start   = 1'b1;
    lastKey = key;
    @(posedge clock);
    #1;
    start   = 1'b0;
    lastKey = ~key;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 400) begin
      if (stray_en) begin
        start   = (keyValid === 1'b1) && (roundNum > 4'd0) && ($urandom_range(0, 1) == 1);
        lastKey = stray_key;
      end
      @(negedge clock);
      cyc++;
      seen = (done === 1'b1);
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 128'(seen), 128'd1);
  endtask

  task automatic do_run(input logic [127:0] key, input bit fips, input string tag, output int cyc);
    int d0 = dones;
    int a0 = accepts;
    int c;
    push_run(key, fips);
    pulse_start(key);
    @(negedge clock);
    check_eq({tag, "_first_valid"}, 128'(keyValid), 128'd1);
    check_eq({tag, "_first_rn"}, 128'(roundNum), 128'd10);
    wait_done(tag, c);
    cyc = c + 1;
    repeat (3) @(negedge clock);
    check_eq({tag, "_accepts"}, 128'(accepts - a0), 128'd11);
    check_eq({tag, "_dones"}, 128'(dones - d0), 128'd1);
    check_eq({tag, "_sb_empty"}, 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    bit found;
    logic [127:0] k;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_m[x] = b ^ rotl1(b) ^ rotl1(rotl1(b)) ^ rotl1(rotl1(rotl1(b)))
                  ^ rotl1(rotl1(rotl1(rotl1(b)))) ^ 8'h63;
    end

    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_valid", 128'(keyValid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_done", 128'(done), 128'd0);
    check_eq("rst_rn", 128'(roundNum), 128'd0);
    check_eq("rst_key", roundKey, 128'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // FIPS-197 vector, always ready: 11 keys back to back.
    do_run(K10, 1'b1, "fips", cyc);
    check_eq("fips_cycles", 128'(cyc), 128'd12);

    rand_ready = 1'b1;
    do_run(K10, 1'b1, "bp", cyc);

    stray_key = {$urandom, $urandom, $urandom, $urandom};
    stray_en  = 1'b1;
    do_run(K10, 1'b1, "stray", cyc);
    stray_en   = 1'b0;
    rand_ready = 1'b0;
    repeat (2) @(negedge clock);

    // Reset in the middle of a run.
    d0 = dones;
    push_run(K10, 1'b1);
    pulse_start(K10);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      found = (keyValid === 1'b1) && (roundNum == 4'd5);
    end
    check_eq("mid_found_r5", 128'(found), 128'd1);
    reset = 1'b0;
    @(negedge clock);
    check_eq("mid_valid", 128'(keyValid), 128'd0);
    check_eq("mid_busy", 128'(busy), 128'd0);
    check_eq("mid_rn", 128'(roundNum), 128'd0);
    sb_q.delete();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("mid_no_done", 128'(dones - d0), 128'd0);
    do_run(K10, 1'b1, "restart", cyc);

    // Back-to-back: start in the done cycle is ignored, one cycle later it runs.
    k = {$urandom, $urandom, $urandom, $urandom};
    push_run(K10, 1'b1);
    pulse_start(K10);
    wait_done("b2b_first", cyc);
    start   = 1'b1;
    lastKey = k;
    @(negedge clock);
    check_eq("b2b_ignored_valid", 128'(keyValid), 128'd0);
    check_eq("b2b_ignored_busy", 128'(busy), 128'd0);
    push_run(k, 1'b0);
    @(negedge clock);
    start   = 1'b0;
    lastKey = '0;
    check_eq("b2b_second_valid", 128'(keyValid), 128'd1);
    check_eq("b2b_second_rn", 128'(roundNum), 128'd10);
    wait_done("b2b_second", cyc);
    repeat (3) @(negedge clock);
    check_eq("b2b_sb_empty", 128'(sb_q.size()), 128'd0);

    // All-zero key: forward expansion of the emitted round-0 key must return it.
    do_run(128'd0, 1'b0, "zero", cyc);
    k = last_r0;
    for (int r = 1; r <= 10; r++) k = m_fwd(k, r);
    check_eq("zero_fwd_regen", k, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
